lsu: RTL and testbench

//  Load/store unit between the core's execute stage and the byte-masked, word-addressed data memory.
//  - Converts funct3-typed accesses (LB/LH/LW/LBU/LHU, SB/SH/SW) into word address, byte mask and lane-shifted write data.
//  - Extracts and sign/zero-extends load data from the memory's asynchronous read word.
//  - Sequences word-crossing misaligned accesses as two back-to-back memory accesses (optional feature).

---
 rtl/lsu.sv | 189 ++++++++++++++++++
 tb/tb_lsu.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: funct3-typed accesses to a byte-masked, word-addressed memory.
// Optional MISALIGNED_SPLIT_EN: word-crossing accesses run as two back-to-back accesses.
module lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_we,
  output logic [3:0]        mem_wmask,
  output logic [ADDR_W-1:0] mem_a,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  // Handshake: a request transfers on a clock edge where req_valid & req_ready;
  // rsp_valid is a single-cycle pulse per accepted request.
  typedef enum logic {IDLE, SPLIT} state_e;

  state_e      state_q, state_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_fault_q, rsp_fault_d;
  logic        mem_we_c;

  logic [1:0]        off, size;
  logic [3:0]        mask_base, lo_mask;
  logic [31:0]       lo_wd, rd_shift;
  logic              bad_f3, misalign_fault, fault, accept;
  logic [ADDR_W-1:0] word_a;

  function automatic logic [31:0] extend(input logic [31:0] sh, input logic [1:0] sz,
                                         input logic uns);
    case (sz)
      2'b00:   extend = {{24{sh[7] & ~uns}}, sh[7:0]};
      2'b01:   extend = {{16{sh[15] & ~uns}}, sh[15:0]};
      default: extend = sh;
    endcase
  endfunction

  assign off      = req_addr[1:0];
  assign size     = req_funct3[1:0];
  assign word_a   = {req_addr[ADDR_W-1:2], 2'b00};
  assign rd_shift = mem_rd >> {off, 3'b000};
  assign bad_f3   = (size == 2'b11) | (req_we & req_funct3[2]);
  assign accept   = req_valid & req_ready;

  always_comb begin
    case (size)
      2'b00:   mask_base = 4'b0001;
      2'b01:   mask_base = 4'b0011;
      default: mask_base = 4'b1111;
    endcase
  end

`ifdef MISALIGNED_SPLIT_EN
  logic [7:0]        mask8;
  logic [63:0]       data64;
  logic [1:0]        nb_m1;
  logic [2:0]        last_b;
  logic              crossing;
  logic [31:0]       split_sh;
  logic [1:0]        off_q, off_d, size_q, size_d;
  logic              uns_q, uns_d, we_q, we_d;
  logic [3:0]        hmask_q, hmask_d;
  logic [31:0]       hwd_q, hwd_d, low_q, low_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign mask8          = {4'b0000, mask_base} << off;
  assign data64         = {32'h0, req_wdata} << {off, 3'b000};
  assign nb_m1          = (size == 2'b00) ? 2'd0 : (size == 2'b01) ? 2'd1 : 2'd3;
  assign last_b         = {1'b0, off} + {1'b0, nb_m1};
  assign crossing       = last_b[2];
  assign lo_mask        = mask8[3:0];
  assign lo_wd          = data64[31:0];
  assign misalign_fault = 1'b0;
  assign split_sh       = 32'({mem_rd, low_q} >> {off_q, 3'b000});

  // Second-half context; no reset needed since it is only read in SPLIT.
  always_ff @(posedge clk) begin
    off_q   <= off_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    we_q    <= we_d;
    hmask_q <= hmask_d;
    hwd_q   <= hwd_d;
    low_q   <= low_d;
    addr_q  <= addr_d;
  end
`else
  assign lo_mask        = mask_base << off;
  assign lo_wd          = req_wdata << {off, 3'b000};
  assign misalign_fault = ((size == 2'b01) & off[0]) | ((size == 2'b10) & (off != 2'b00));
`endif

  assign fault = bad_f3 | misalign_fault;

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_fault_d = 1'b0;
    mem_a       = word_a;
    mem_wmask   = lo_mask;
    mem_wd      = lo_wd;
    mem_we_c    = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    hmask_d = hmask_q;
    hwd_d   = hwd_q;
    low_d   = low_q;
    addr_d  = addr_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (fault) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
          end
`ifdef MISALIGNED_SPLIT_EN
          else if (crossing) begin
            mem_we_c = req_we;
            state_d  = SPLIT;
            off_d    = off;
            size_d   = size;
            uns_d    = req_funct3[2];
            we_d     = req_we;
            hmask_d  = mask8[7:4];
            hwd_d    = data64[63:32];
            low_d    = mem_rd;
            addr_d   = word_a + ADDR_W'(4);
          end
`endif
          else begin
            mem_we_c    = req_we;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = req_we ? 32'h0 : extend(rd_shift, size, req_funct3[2]);
          end
        end
      end
`ifdef MISALIGNED_SPLIT_EN
      SPLIT: begin
        mem_a       = addr_q;
        mem_wmask   = hmask_q;
        mem_wd      = hwd_q;
        mem_we_c    = we_q;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = we_q ? 32'h0 : extend(split_sh, size_q, uns_q);
        state_d     = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  // Reset drops a pending second half, so the write strobe is gated by reset directly.
  assign mem_we    = mem_we_c & ~reset;
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: byte-array reference model, word memory behind the DUT.
module tb_lsu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_a, mem_wd, mem_rd;

  always #5 clk = ~clk;

  lsu #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // 1 KiB memory; high addresses alias onto it, which also exercises address wrap.
  logic [31:0] mem [0:255];
  logic [31:0] img [0:255];
  logic        bd_load;

  always @(posedge clk) begin
    if (bd_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_a[9:2]][8*b +: 8] <= mem_wd[8*b +: 8];
    end
  end
  assign mem_rd = mem[mem_a[9:2]];

  logic [7:0] ref_b [0:1023];
  int total = 0;
  int bad   = 0;

  logic [31:0] obs_a0, obs_d0, obs_a1, obs_d1, obs_rdata;
  logic [3:0]  obs_m0, obs_m1;
  logic        obs_we0, obs_rdy1, obs_we_seen, obs_fault;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit split_en();
`ifdef MISALIGNED_SPLIT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: whole access computed at byte granularity from the access rules.
  task automatic ref_access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] rdata,
                            output bit fault, output int lat);
    int n, off;
    logic [31:0] v;
    n     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off   = int'(addr[1:0]);
    fault = (f3[1:0] == 2'b11) || (we && f3[2]) || (!split_en() && (off % n) != 0);
    rdata = 32'h0;
    lat   = (!fault && split_en() && off + n > 4) ? 2 : 1;
    if (!fault) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_b[10'(addr + 32'(i))] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[10'(addr + 32'(i))];
        if (!f3[2] && v[8*n-1])
          for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        rdata = v;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge where rsp_valid is seen so the
  // next call can issue back-to-back.
  task automatic do_access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
    logic [31:0] er;
    bit          ef, got;
    int          el, lat;
    ref_access(we, f3, addr, wd, er, ef, el);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    #1;
    check("ready_idle", req_ready, 1);
    obs_a0 = mem_a; obs_m0 = mem_wmask; obs_d0 = mem_wd; obs_we0 = mem_we;
    obs_we_seen = mem_we; obs_rdy1 = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 4) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) got = 1'b1;
      else begin
        if (lat == 1) begin
          obs_a1 = mem_a; obs_m1 = mem_wmask; obs_d1 = mem_wd; obs_rdy1 = req_ready;
        end
        obs_we_seen = obs_we_seen | mem_we;
      end
    end
    obs_rdata = rsp_rdata; obs_fault = rsp_fault;
    check("rsp_timeout", got, 1);
    if (got) begin
      check("latency", lat, el);
      check("rdata", rsp_rdata, er);
      check("fault", rsp_fault, ef);
    end
    check("we_seen", obs_we_seen, we && !ef);
  endtask

  initial begin
    logic [31:0] exp_w;
    for (int i = 0; i < 256; i++) begin
      img[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_b[4*i+b] = img[i][8*b +: 8];
    end
    bd_load = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h80; req_wdata = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_fault", rsp_fault, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_ready", req_ready, 1);
    bd_load = 1'b0; reset = 1'b0; req_valid = 1'b0;

    // SB lane placement
    do_access(1'b1, 3'b000, 32'h103, 32'h000000AB);
    check("sb_a", obs_a0, 32'h100);
    check("sb_mask", obs_m0, 4'b1000);
    check("sb_wd", obs_wd_fix(obs_d0), 32'hAB000000);
    check("sb_we", obs_we0, 1);

    // Sign/zero extension from one word
    do_access(1'b1, 3'b010, 32'h20, 32'h80F01234);
    do_access(1'b0, 3'b000, 32'h23, 32'h0); check("lb", obs_rdata, 32'hFFFFFF80);
    do_access(1'b0, 3'b100, 32'h23, 32'h0); check("lbu", obs_rdata, 32'h00000080);
    do_access(1'b0, 3'b001, 32'h20, 32'h0); check("lh", obs_rdata, 32'h00001234);
    do_access(1'b0, 3'b101, 32'h22, 32'h0); check("lhu", obs_rdata, 32'h000080F0);

    // Crossing load
    do_access(1'b1, 3'b010, 32'h40, 32'h11223344);
    do_access(1'b1, 3'b010, 32'h44, 32'h55667788);
    do_access(1'b0, 3'b010, 32'h43, 32'h0);
`ifdef MISALIGNED_SPLIT_EN
    check("lw_cross", obs_rdata, 32'h66778811);
`else
    check("lw_cross_fault", obs_fault, 1);
`endif

    // Crossing store
    do_access(1'b1, 3'b010, 32'h42, 32'hDDCCBBAA);
`ifdef MISALIGNED_SPLIT_EN
    check("sw_a0", obs_a0, 32'h40);
    check("sw_m0", obs_m0, 4'b1100);
    check("sw_d0", obs_d0, 32'hBBAA0000);
    check("sw_a1", obs_a1, 32'h44);
    check("sw_m1", obs_m1, 4'b0011);
    check("sw_d1", obs_d1, 32'h0000DDCC);
    check("sw_ready1", obs_rdy1, 0);
`else
    check("sw_cross_fault", obs_fault, 1);
`endif

    // Invalid funct3
    do_access(1'b0, 3'b011, 32'h10, 32'h0);  check("f3_011_fault", obs_fault, 1);
    do_access(1'b1, 3'b100, 32'h14, 32'hFFFFFFFF); check("f3_100_fault", obs_fault, 1);

    // Wrap across the top of the address space
    do_access(1'b1, 3'b010, 32'hFFFFFFFE, 32'hCAFEF00D);
    do_access(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);

`ifdef MISALIGNED_SPLIT_EN
    // Reset while in SPLIT: first half committed, second half dropped, no response
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h81; req_wdata = 32'h99887766;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) ref_b[10'h81 + 10'(i)] = req_wdata[8*i +: 8];
    @(negedge clk);
    check("split_ready0", req_ready, 0);
    reset = 1'b1;
    #1;
    check("split_reset_we", mem_we, 0);
    @(negedge clk);
    check("split_reset_rsp", rsp_valid, 0);
    check("split_reset_ready", req_ready, 1);
    reset = 1'b0;
    @(negedge clk);
    check("split_reset_rsp2", rsp_valid, 0);
`endif

    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? {22'h3FFFFF, 10'($urandom)} : 32'($urandom_range(0, 1023));
      repeat ($urandom_range(0, 1)) @(negedge clk);
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end

    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      exp_w = {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
      check($sformatf("mem_word_%0d", i), mem[i], exp_w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic [31:0] obs_wd_fix(input logic [31:0] d);
    return d;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
